// File: rtl/memwb.sv
// Memory/writeback stage: forwards ALU results or runs one load/store over a
// single-outstanding req/ack bus, then returns a one-cycle register-file write.
module memwb #(
  parameter int RW    = 16,
  parameter int REGNO = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_submit,
  output logic             o_ready,
  input  logic [RW-1:0]    i_addr,
  input  logic [RW-1:0]    i_data,
  input  logic [REGNO-1:0] i_reg_ie,
  input  logic             i_mem_access,
  input  logic             i_mem_we,
  input  logic             i_mem_width,
  input  logic             i_data_page,
  output logic [REGNO-1:0] o_reg_ie,
  output logic [RW-1:0]    o_reg_data,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [RW-1:0]    o_mem_addr,
  output logic [1:0]       o_mem_sel,
  output logic [RW-1:0]    o_mem_data,
  output logic             o_mem_page,
  input  logic             i_mem_ack,
  input  logic [RW-1:0]    i_mem_data
);

  typedef enum logic {IDLE, BUS} state_t;

  // What the load return path needs once the ack arrives.
  typedef struct packed {
    logic             bsel;
    logic             hi;
    logic [REGNO-1:0] reg_ie;
  } pend_t;

  state_t        state, state_nx;
  pend_t         pend;
  logic          accept, done;
  logic [RW-1:0] rd_fmt;

  assign o_ready   = (state == IDLE);
  assign o_mem_req = (state == BUS);
  assign accept    = o_ready & i_submit;
  assign done      = o_mem_req & i_mem_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == IDLE) begin
      if (i_submit && i_mem_access) state_nx = BUS;
    end else begin
      if (i_mem_ack) state_nx = IDLE;
    end
  end

  always_comb begin
    rd_fmt = i_mem_data;
    if (pend.bsel)
      rd_fmt = {{(RW-8){1'b0}}, pend.hi ? i_mem_data[15:8] : i_mem_data[7:0]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_reg_ie   <= '0;
      o_reg_data <= '0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_sel  <= '0;
      o_mem_data <= '0;
      o_mem_page <= 1'b0;
      pend       <= '0;
    end else begin
      o_reg_ie <= '0;
      if (accept && !i_mem_access) begin
        o_reg_ie   <= i_reg_ie;
        o_reg_data <= i_data;
      end else if (accept) begin
        o_mem_we    <= i_mem_we;
        o_mem_addr  <= i_addr;
        o_mem_sel   <= i_mem_width ? (i_addr[0] ? 2'b10 : 2'b01) : 2'b11;
        o_mem_data  <= i_mem_width ? {(RW/8){i_data[7:0]}} : i_data;
        o_mem_page  <= i_data_page;
        pend.bsel   <= i_mem_width;
        pend.hi     <= i_addr[0];
        pend.reg_ie <= i_reg_ie;
      end else if (done && !o_mem_we) begin
        // Stores never write back, whatever reg_ie was latched.
        o_reg_ie   <= pend.reg_ie;
        o_reg_data <= rd_fmt;
      end
    end
  end

endmodule

// File: doc/memwb.md
# memwb

Memory/writeback stage directly downstream of the execute stage. Accepts one instruction per cycle from execute. Performs loads and stores over a single-outstanding request/acknowledge data bus with 8/16-bit width handling. Returns register-file write enables and data to execute's register file.

## Interface
Parameters:
- RW, 16, datapath/address width (equals `RW)
- REGNO, 8, number of architectural registers (equals `REGNO)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_submit  in  1  execute has a valid instruction this cycle
- o_ready  out  1  stage can accept an instruction this cycle
- i_addr  in  RW  byte address (ALU result)
- i_data  in  RW  store data, or result for non-memory ops
- i_reg_ie  in  REGNO  one-hot destination register enable (all-zero = no write)
- i_mem_access  in  1  instruction is a load/store
- i_mem_we  in  1  1 = store, 0 = load
- i_mem_width  in  1  1 = byte, 0 = 16-bit word
- i_data_page  in  1  data paging enable, sampled at accept
- o_reg_ie  out  REGNO  register-file write enable, one-cycle pulse
- o_reg_data  out  RW  register-file write data
- o_mem_req  out  1  bus request, held until acknowledged
- o_mem_we  out  1  bus write
- o_mem_addr  out  RW  byte address
- o_mem_sel  out  2  byte lane select: [0] = low byte, [1] = high byte
- o_mem_data  out  RW  bus write data
- o_mem_page  out  1  paging flag for the access
- i_mem_ack  in  1  bus completes the current request this cycle
- i_mem_data  in  RW  bus read data, valid with i_mem_ack

## Operation
- Accept: i_submit & o_ready. i_submit while o_ready=0 is ignored; upstream never does this.
- States: IDLE, BUS.
  - IDLE: o_ready=1, o_mem_req=0.
  - BUS: o_ready=0, o_mem_req=1.
- Non-memory accept (i_mem_access=0), state stays IDLE:
  - next cycle o_reg_ie=i_reg_ie, o_reg_data=i_data.
- Memory accept: latch addr, we, width, reg_ie, page; go to BUS.
  - Bus outputs are registered and stable for the whole BUS state.
- Lane select:
  - word: o_mem_sel=2'b11.
  - byte: o_mem_sel = i_addr[0] ? 2'b10 : 2'b01.
  - Word accesses at odd addresses are not checked; sel=11 and addr are passed unchanged.
- Store data:
  - word: o_mem_data=i_data.
  - byte: o_mem_data={i_data[7:0], i_data[7:0]}.
- BUS and i_mem_ack → IDLE.
  - Load: next cycle o_reg_ie=latched reg_ie and o_reg_data = formatted read.
    - word: i_mem_data.
    - byte: zero-extended i_mem_data[15:8] if addr[0], else i_mem_data[7:0].
  - Store: o_reg_ie=0 regardless of latched reg_ie.
- i_mem_ack in IDLE is ignored.
- o_reg_ie is zero in every cycle with no writeback, including bubbles and the BUS wait cycles.

## Timing
- Reset values:
  - state IDLE, o_ready=1, o_mem_req=0, o_mem_we=0.
  - o_reg_ie=0, o_reg_data=0, o_mem_addr=0, o_mem_sel=0, o_mem_data=0, o_mem_page=0.
- Non-memory op accepted in cycle T: writeback pulse in T+1; back-to-back accepts every cycle.
- Memory op accepted in T:
  - o_mem_req=1 and o_ready=0 from T+1.
  - If ack arrives in cycle A (A ≥ T+1): o_mem_req=0 and o_ready=1 in A+1.
  - Load writeback pulse in A+1.
  - A new instruction may be accepted in A+1.
  - Minimum occupancy is 2 cycles (T+1 to T+2).
- Ack is sampled only at a rising edge in BUS. Request must not drop before ack.
- Reset during BUS:
  - o_mem_req drops next cycle and the writeback is discarded.
  - The bus must tolerate the abandoned request.
- Flushes never reach this stage: an accepted instruction is architecturally committed and always completes.

## Test plan
- Reset → o_ready=1, o_mem_req=0, o_reg_ie=0 at the first post-reset edge.
- 3 back-to-back ALU ops, i_reg_ie=8'h01/02/04, i_data=16'h1111/2222/3333 → o_reg_ie pulses 01/02/04 with matching data on T+1..T+3; o_ready stays 1.
- Word load, addr=16'h0040, i_reg_ie=8'h08, ack after 3 wait cycles with i_mem_data=16'hBEEF → o_mem_sel=11, o_ready low 4 cycles, then o_reg_ie=08 and o_reg_data=BEEF.
- Byte load, addr=16'h0041, ack at the first BUS cycle with i_mem_data=16'hA55A → o_mem_sel=10, o_reg_data=16'h00A5.
- Byte store, addr=16'h0010, i_data=16'h12C3, i_reg_ie=8'h02 → o_mem_we=1, o_mem_sel=01, o_mem_data=16'hC3C3; o_reg_ie stays 0 after ack.
- Reset asserted in the second BUS cycle, then ack pulsed → o_mem_req=0 after reset and no writeback pulse; a stray ack in IDLE causes no state change.
